// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock/baud settings
// and the bit-period formulas used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQUENCY = 27;      // MHz
  localparam int unsigned DEFAULT_BAUD_RATE     = 115200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clk_cycle(input int unsigned freq_mhz,
                                            input int unsigned baud);
    return (freq_mhz * 1000000) / baud;
  endfunction

  function automatic int unsigned half_cycle(input int unsigned freq_mhz,
                                             input int unsigned baud);
    return clk_cycle(freq_mhz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: clk, rst (sync, active-high, presets flops to idle-high),
//        d (async input), q (synchronized output).
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 even parity, 1 stop.
// Ports: i_clk, i_rst (sync active-high), i_rx (async line, idle high),
//        data_received (last byte), rx_valid (1-cycle pulse qualifying
//        data_received/parity_err/frame_err), parity_err, frame_err,
//        busy_rx (FSM not idle).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_frequency = DEFAULT_CLK_FREQUENCY,
  parameter int unsigned baud_rate     = DEFAULT_BAUD_RATE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] data_received,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy_rx
);

  localparam int unsigned CLK_CYCLE  = clk_cycle(clk_frequency, baud_rate);
  localparam int unsigned HALF_CYCLE = half_cycle(clk_frequency, baud_rate);
  localparam logic [7:0]  BIT_LAST   = 8'(CLK_CYCLE - 1);
  localparam logic [7:0]  HALF_LAST  = 8'(HALF_CYCLE - 1);

  uart_state_t state, state_next;
  logic        rx_s;
  logic [7:0]  cnt;
  logic [2:0]  bit_index;
  logic [7:0]  shift;
  logic        parity_bad;
  logic        tick;

  uart_sync u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  // Terminal count of the bit-period counter: half a bit in START (to land
  // mid start bit), a full bit afterwards (to land mid every later bit).
  always_comb begin
    tick = 1'b0;
    unique case (state)
      START:              tick = (cnt == HALF_LAST);
      DATA, PARITY, STOP: tick = (cnt == BIT_LAST);
      default:            tick = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_index == 3'd7) state_next = PARITY;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt           <= '0;
      bit_index     <= '0;
      shift         <= '0;
      parity_bad    <= 1'b0;
      data_received <= '0;
      rx_valid      <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      if (state_next != state || tick)
        cnt <= '0;
      else if (state != IDLE && state != BREAK)
        cnt <= cnt + 8'd1;

      unique case (state)
        DATA: if (tick) begin
          shift[bit_index] <= rx_s;
          bit_index        <= bit_index + 3'd1;  // wraps to 0 after bit 7
        end
        PARITY: if (tick) parity_bad <= rx_s ^ (^shift);
        // Outputs register on the stop sample edge, so they and the
        // rx_valid pulse appear in the following cycle.
        STOP: if (tick) begin
          rx_valid      <= 1'b1;
          data_received <= shift;
          parity_err    <= parity_bad;
          frame_err     <= ~rx_s;
        end
        default: ;
      endcase
    end
  end

  assign busy_rx = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned CLK  = (27 * 1000000) / 115200;  // 234
  localparam int unsigned HALF = CLK / 2;                   // 117
  // Stop bit is sampled around 10.5 bit periods after the start edge, plus a
  // few cycles of synchronizer/FSM latency.
  localparam int unsigned LAT_MIN = 10 * CLK + HALF - 2;
  localparam int unsigned LAT_MAX = 10 * CLK + HALF + 6;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx  = 1'b1;
  logic [7:0] data_received;
  logic       rx_valid, parity_err, frame_err, busy_rx;

  uart_rx #(.clk_frequency(27), .baud_rate(115200)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rx          (i_rx),
    .data_received (data_received),
    .rx_valid      (rx_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy_rx       (busy_rx)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc++;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned t0;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned valid_cnt = 0;

  // Scoreboard: each rx_valid pulse consumes one expected frame.
  always @(negedge i_clk) begin
    if (rx_valid) begin
      frame_t e;
      valid_cnt++;
      if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("data", {24'd0, data_received}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        check("latency_ok",
              {31'd0, (cyc - e.t0 >= LAT_MIN) && (cyc - e.t0 <= LAT_MAX)}, 32'd1);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the line at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input int unsigned stop_periods);
    logic [9:0] bits;
    frame_t     e;
    bits    = {par, d, 1'b0};
    e.data  = d;
    e.perr  = par ^ (^d);
    e.ferr  = ~stp;
    e.t0    = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      idle(CLK);
    end
    i_rx = stp;
    idle(CLK * stop_periods);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'(ones % 2);
  endfunction

  initial begin
    int unsigned base;
    logic [7:0]  d, last;
    logic [7:0]  bad;

    idle(3);
    i_rst = 1'b0;
    #1;
    check("rst_data", {24'd0, data_received}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy_rx}, 32'd0);
    idle(20);

    // Clean frame and parity-error frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    idle(50);
    send_frame(8'h01, 1'b0, 1'b1, 1);
    idle(50);

    // Short glitch on the line: no frame.
    base = valid_cnt;
    i_rx = 1'b0;
    idle(50);
    i_rx = 1'b1;
    idle(300);
    check("glitch_no_valid", valid_cnt, base);
    check("glitch_idle", {31'd0, busy_rx}, 32'd0);

    // Framing error with line held low, then recovery.
    send_frame(8'h3C, even_par(8'h3C), 1'b0, 3);
    check("break_valid_seen", valid_cnt, base + 1);
    check("break_busy", {31'd0, busy_rx}, 32'd1);
    check("break_ferr_held", {31'd0, frame_err}, 32'd1);
    i_rx = 1'b1;
    idle(10);
    check("break_exit", {31'd0, busy_rx}, 32'd0);
    send_frame(8'h55, even_par(8'h55), 1'b1, 1);
    idle(20);

    // Back-to-back frames.
    send_frame(8'h00, even_par(8'h00), 1'b1, 1);
    send_frame(8'hFF, even_par(8'hFF), 1'b1, 1);
    send_frame(8'h80, even_par(8'h80), 1'b1, 1);
    idle(50);

    // Reset during data bit 4 of 0x9B.
    base = valid_cnt;
    d = 8'h9B;
    i_rx = 1'b0;
    idle(CLK);
    for (int i = 0; i < 4; i++) begin
      i_rx = d[i];
      idle(CLK);
    end
    i_rx = d[4];
    idle(HALF);
    check("pre_rst_busy", {31'd0, busy_rx}, 32'd1);
    i_rst = 1'b1;
    idle(1);
    i_rst = 1'b0;
    i_rx  = 1'b1;
    #1;
    check("mid_rst_data", {24'd0, data_received}, 32'd0);
    check("mid_rst_flags", {29'd0, rx_valid, parity_err, frame_err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_rx}, 32'd0);
    idle(CLK * 12);
    check("mid_rst_no_valid", valid_cnt, base);
    send_frame(8'h12, even_par(8'h12), 1'b1, 1);
    idle(30);

    // Random frames, occasional bad parity, random idle gaps.
    last = 8'h12;
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom_range(0, 255));
      bad  = 8'($urandom_range(0, 3));
      last = d;
      send_frame(d, even_par(d) ^ (bad == 8'd0), 1'b1, 1);
      idle($urandom_range(0, 300));
    end

    for (int w = 0; w < 5000 && exp_q.size() != 0; w++) idle(1);
    check("queue_drained", exp_q.size(), 32'd0);

    idle(500);
    check("hold_data", {24'd0, data_received}, {24'd0, last});
    check("hold_valid_low", {31'd0, rx_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clk_frequency, default 27, SHALL be the clock frequency in MHz.
REQ-002 Parameter baud_rate, default 115200, SHALL be the serial bit rate.
REQ-003 Port i_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, SHALL be synchronous and active-high.
REQ-005 Port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port data_received, output, 8 bits: last received byte.
REQ-007 Port rx_valid, output, 1 bit: one-cycle pulse; data_received, parity_err and frame_err are valid in that cycle.
REQ-008 Port parity_err, output, 1 bit: even-parity mismatch on the frame flagged by rx_valid.
REQ-009 Port frame_err, output, 1 bit: stop bit sampled low on the frame flagged by rx_valid.
REQ-010 Port busy_rx, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 Frame SHALL be 1 start (0), 8 data LSB-first, 1 even parity, 1 stop (1).
REQ-012 Bit period CLK_CYCLE SHALL be (clk_frequency*1000000)/baud_rate, integer division (234 at defaults); HALF_CYCLE SHALL be CLK_CYCLE/2 (117).
REQ-013 i_rx SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value rx_s.
REQ-014 The bit-period counter SHALL be 8 bits wide, SHALL clear on every state change, and SHALL clear on reaching its terminal count.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 IDLE -> START when rx_s == 0.
REQ-017 In START, at counter == HALF_CYCLE-1: if rx_s == 0, go to DATA with the counter cleared; if rx_s == 1 (glitch), return to IDLE with no rx_valid.
REQ-018 In DATA, rx_s SHALL be sampled at counter == CLK_CYCLE-1 into shift bit bit_index (3 bits, 0..7); after bit 7, go to PARITY.
REQ-019 In PARITY, rx_s SHALL be sampled at counter == CLK_CYCLE-1; parity_err = sampled bit XOR (^data); then go to STOP.
REQ-020 In STOP, rx_s SHALL be sampled at counter == CLK_CYCLE-1; the next cycle SHALL update data_received, parity_err and frame_err and pulse rx_valid for exactly one cycle.
REQ-021 STOP -> IDLE if the stop sample is 1; otherwise STOP -> BREAK with frame_err = 1.
REQ-022 BREAK -> IDLE only when rx_s == 1; no new start SHALL be detected while in BREAK.
REQ-023 rx_valid SHALL be issued even when an error flag is set; errors qualify, they do not suppress.
REQ-024 data_received, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-025 A start bit arriving immediately after the stop mid-sample (back-to-back frames) SHALL be accepted with no lost frame.
REQ-026 No receive-side flow control: a new frame SHALL overwrite the outputs whether or not they were consumed.

Reset
REQ-027 On i_rst = 1 at a clock edge: state IDLE, counter 0, bit_index 0, shift register 0, synchronizer flops 1.
REQ-028 On reset, output values SHALL be: data_received 0, rx_valid 0, parity_err 0, frame_err 0, busy_rx 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no rx_valid; reception SHALL resume on the next falling edge of the line.

Structure
REQ-030 A shared uart_pkg SHALL hold the state encodings (3 bits), the default clk_frequency and baud_rate, and the CLK_CYCLE/HALF_CYCLE formulas; uart_tx and uart_rx SHALL both use it.
REQ-031 The 2-flop synchronizer SHALL be one sub-module, uart_sync; everything else is flat in uart_rx.

Verification
REQ-032 Byte 0xA5, parity 0, stop 1 -> one rx_valid pulse, data_received = 0xA5, parity_err = 0, frame_err = 0.
REQ-033 Byte 0x01 sent with parity 0 -> data_received = 0x01, parity_err = 1, frame_err = 0.
REQ-034 Line low for 50 cycles, then high -> no rx_valid, FSM back in IDLE, busy_rx low.
REQ-035 Byte 0x3C with stop 0, line held low 3 bit periods, then high -> rx_valid with frame_err = 1, data_received = 0x3C; no further frame until the line goes high; next frame 0x55 received cleanly.
REQ-036 Back-to-back frames 0x00, 0xFF, 0x80 -> three rx_valid pulses in order, all error flags 0.
REQ-037 i_rst pulsed during DATA bit 4 of 0x9B -> no rx_valid for that frame, outputs at reset values; following frame 0x12 received correctly.
